// File: rtl/alu_issuer_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, FSM states, default width.
package alu_issuer_pkg;

  localparam int W_DEFAULT = 5;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_HOLD = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_issuer.sv
// ALU command issuer: accepts one command at a time, drives an external
// combinational ALU for one EXEC cycle (LOAD bypasses it), keeps the
// accumulator and presents the result with a valid/ready handshake.
// Optional feature: define ALU_ISSUER_OVF_EN to add the registered ovf output
// flagging signed overflow of ADD/SUB.
module alu_issuer
  import alu_issuer_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic signed [W-1:0] cmd_data,
  output logic signed [W-1:0] alu_din1,
  output logic signed [W-1:0] alu_din2,
  output logic [1:0]          alu_sel,
  input  logic signed [W-1:0] alu_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic signed [W-1:0] res_data,
  output logic signed [W-1:0] acc
`ifdef ALU_ISSUER_OVF_EN
  ,
  output logic                ovf
`endif
);

  state_t state;

`ifdef ALU_ISSUER_OVF_EN
  // Signed overflow: operands effectively share a sign (b is negated for SUB)
  // while the wrapped result's sign differs from a's.
  function automatic logic ovf_calc(input logic [1:0] sel,
                                    input logic signed [W-1:0] a,
                                    input logic signed [W-1:0] b,
                                    input logic signed [W-1:0] r);
    logic sa, sb, sr;
    sa = a[W-1];
    sb = b[W-1];
    sr = r[W-1];
    case (sel)
      OP_ADD:  ovf_calc = (sa == sb) && (sr != sa);
      OP_SUB:  ovf_calc = (sa != sb) && (sr != sa);
      default: ovf_calc = 1'b0;
    endcase
  endfunction
`endif

  // Issuer FSM with all outputs registered; reset discards any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      acc       <= '0;
      res_data  <= '0;
      alu_din1  <= '0;
      alu_din2  <= '0;
      alu_sel   <= '0;
`ifdef ALU_ISSUER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_op == OP_LOAD) begin
              // LOAD skips the ALU; alu_* keep their last values.
              acc       <= cmd_data;
              res_data  <= cmd_data;
              res_valid <= 1'b1;
`ifdef ALU_ISSUER_OVF_EN
              ovf       <= 1'b0;
`endif
              state     <= ST_RESP;
            end else begin
              // acc is frozen until end of EXEC, so din1 stays consistent with it.
              alu_din1 <= acc;
              alu_din2 <= cmd_data;
              alu_sel  <= cmd_op;
              state    <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          acc       <= alu_out;
          res_data  <= alu_out;
          res_valid <= 1'b1;
`ifdef ALU_ISSUER_OVF_EN
          ovf       <= ovf_calc(alu_sel, alu_din1, alu_din2, alu_out);
`endif
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
